// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: reverse double-dabble BCD-to-binary converter with start/valid handshake and invalid-digit flag
module bcd2bin_seq #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [BIN_WIDTH-1:0]    o_bin,
  output logic                    o_err
);
  localparam int SW = 4*NUM_DIGITS + BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t              state_q, state_d;
  logic [SW-1:0]        sr_q, sr_d, sh, corr;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d, oerr_q, oerr_d, bad, accept, conv, last;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      oerr_q  <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      oerr_q  <= oerr_d;
      bin_q   <= bin_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (i_start ? CONV : IDLE) :
              state_q == CONV ? (last ? DONE : CONV) : IDLE;
  end
  always_comb begin
    accept = state_q == IDLE && i_start;
    conv   = state_q == CONV;
    last   = cnt_q == CW'(BIN_WIDTH - 1);
    bad    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) bad = bad | (i_bcd[4*i +: 4] > 4'd9);
    sh   = sr_q >> 1;
    corr = sh;
    for (int i = 0; i < NUM_DIGITS; i++)
      corr[BIN_WIDTH+4*i +: 4] = sh[BIN_WIDTH+4*i +: 4] >= 4'd8 ? sh[BIN_WIDTH+4*i +: 4] - 4'd3 : sh[BIN_WIDTH+4*i +: 4];
    sr_d   = accept ? {i_bcd, {BIN_WIDTH{1'b0}}} : conv ? corr : sr_q;
    cnt_d  = accept ? '0 : conv ? cnt_q + 1'b1 : cnt_q;
    err_d  = accept ? bad : err_q;
    bin_d  = conv && last ? (err_q ? '0 : corr[BIN_WIDTH-1:0]) : bin_q;
    oerr_d = conv && last ? err_q : oerr_q;
  end
  always_comb begin
    o_busy  = state_q != IDLE;
    o_valid = state_q == DONE;
    o_bin   = bin_q;
    o_err   = oerr_q;
  end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: scoreboard bench for bcd2bin_seq with directed vectors
module tb_bcd2bin_seq;
  logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic [11:0] i_bcd = '0;
  logic        o_busy, o_valid, o_err;
  logic [9:0]  o_bin;
  logic [10:0] q[$];
  logic [9:0]  last_bin = '0;
  logic        last_err = 1'b0;
  int          total = 0, bad = 0;
  bcd2bin_seq dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_bcd(i_bcd),
    .o_busy(o_busy), .o_valid(o_valid), .o_bin(o_bin), .o_err(o_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("valid_in_reset", int'(o_valid), 0);
      last_bin = '0;
      last_err = 1'b0;
    end else if (o_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        logic [10:0] e;
        e = q.pop_front();
        chk("bin", int'(o_bin), int'(e[9:0]));
        chk("err", int'(o_err), int'(e[10]));
      end
      last_bin = o_bin;
      last_err = o_err;
    end else begin
      chk("hold_bin", int'(o_bin), int'(last_bin));
      chk("hold_err", int'(o_err), int'(last_err));
    end
  end
  task automatic run(input logic [11:0] bcd, input logic [9:0] eb, input logic ee,
                     input int pa, input int pb, input int ra);
    int n = 0;
    while (o_busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("idle_before_start", int'(o_busy), 0);
    i_bcd = bcd;
    i_start = 1'b1;
    q.push_back({ee, eb});
    @(posedge clk); #1;
    i_start = 1'b0;
    i_bcd = ~bcd;
    chk("busy_after_accept", int'(o_busy), 1);
    n = 0;
    while (!o_valid && n < 30) begin
      n++;
      i_start = (n == pa || n == pb);
      if (n == ra) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_bin", int'(o_bin), 0);
        chk("rst_err", int'(o_err), 0);
        void'(q.pop_back());
        i_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    chk("latency", n, 10);
    @(posedge clk); #1;
    chk("idle_after_done", int'(o_busy), 0);
  endtask
  initial begin
    int acc;
    logic pb;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_bin", int'(o_bin), 0);
    chk("reset_err", int'(o_err), 0);
    rst = 1'b0;
    run(12'h004, 10'd4, 1'b0, 0, 0, 0);
    run(12'h010, 10'd10, 1'b0, 0, 0, 0);
    run(12'h064, 10'd64, 1'b0, 0, 0, 0);
    run(12'h128, 10'd128, 1'b0, 0, 0, 0);
    run(12'h255, 10'd255, 1'b0, 0, 0, 0);
    run(12'h999, 10'd999, 1'b0, 0, 0, 0);
    run(12'h000, 10'd0, 1'b0, 0, 0, 0);
    run(12'h1A3, 10'd0, 1'b1, 0, 0, 0);
    run(12'h123, 10'd123, 1'b0, 0, 0, 0);
    run(12'h456, 10'd456, 1'b0, 3, 9, 0);
    run(12'h789, 10'd0, 1'b0, 0, 0, 5);
    run(12'h789, 10'd789, 1'b0, 0, 0, 0);
    acc = 0;
    pb = o_busy;
    i_bcd = 12'h321;
    i_start = 1'b1;
    for (int c = 0; c < 66; c++) begin
      @(posedge clk); #1;
      if (o_busy && !pb) begin q.push_back({1'b0, 10'd321}); acc++; end
      pb = o_busy;
    end
    i_start = 1'b0;
    chk("held_start_accepts", int'(acc >= 5 && acc <= 7), 1);
    for (int c = 0; c < 20 && o_busy; c++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
